// File: rtl/spec_free_list_pkg.sv
// spec_free_list_pkg: shared sizes, types and pointer helpers for the free list
package spec_free_list_pkg;
    localparam int SIZE_PHYSICAL_TABLE = 96;
    localparam int SIZE_RMT            = 32;
    localparam int SIZE_PHYSICAL_LOG   = 7;
    localparam int SIZE_FREE_LIST      = SIZE_PHYSICAL_TABLE - SIZE_RMT;
    localparam int SIZE_FREE_LIST_LOG  = 6;
    localparam int WIDTH               = 4;

    typedef logic [SIZE_PHYSICAL_LOG-1:0]  phys_t;
    typedef logic [SIZE_FREE_LIST_LOG-1:0] ptr_t;
    typedef logic [SIZE_FREE_LIST_LOG:0]   cnt_t;
    typedef logic [2:0]                    num_t;

    // Advance a circular pointer by k; the depth need not be a power of two.
    function automatic ptr_t ptr_add(ptr_t p, num_t k);
        cnt_t s;
        s = {1'b0, p} + cnt_t'(k);
        return (s >= cnt_t'(SIZE_FREE_LIST)) ? ptr_t'(s - cnt_t'(SIZE_FREE_LIST)) : ptr_t'(s);
    endfunction

    function automatic num_t count4(logic [3:0] v);
        return num_t'(v[0]) + num_t'(v[1]) + num_t'(v[2]) + num_t'(v[3]);
    endfunction
endpackage

// File: rtl/spec_free_list_if.sv
// spec_free_list_if: rename request, commit release and recovery signals of the free list
interface spec_free_list_if;
    import spec_free_list_pkg::*;
    logic  reqValid0_i, reqValid1_i, reqValid2_i, reqValid3_i;
    logic  releasedValid0_i, releasedValid1_i, releasedValid2_i, releasedValid3_i;
    phys_t releasedPhyMap0_i, releasedPhyMap1_i, releasedPhyMap2_i, releasedPhyMap3_i;
    logic  recoverFlag_i;
    phys_t freePhyReg0_o, freePhyReg1_o, freePhyReg2_o, freePhyReg3_o;
    logic  freeListEmpty_o;
    cnt_t  freeCount_o;

    modport master (
        output reqValid0_i, reqValid1_i, reqValid2_i, reqValid3_i,
        output releasedValid0_i, releasedValid1_i, releasedValid2_i, releasedValid3_i,
        output releasedPhyMap0_i, releasedPhyMap1_i, releasedPhyMap2_i, releasedPhyMap3_i,
        output recoverFlag_i,
        input  freePhyReg0_o, freePhyReg1_o, freePhyReg2_o, freePhyReg3_o,
        input  freeListEmpty_o, freeCount_o
    );

    modport slave (
        input  reqValid0_i, reqValid1_i, reqValid2_i, reqValid3_i,
        input  releasedValid0_i, releasedValid1_i, releasedValid2_i, releasedValid3_i,
        input  releasedPhyMap0_i, releasedPhyMap1_i, releasedPhyMap2_i, releasedPhyMap3_i,
        input  recoverFlag_i,
        output freePhyReg0_o, freePhyReg1_o, freePhyReg2_o, freePhyReg3_o,
        output freeListEmpty_o, freeCount_o
    );
endinterface

// File: rtl/free_list_write_align.sv
// free_list_write_align: packs sparse valid release slots into consecutive write lanes
module free_list_write_align
    import spec_free_list_pkg::*;
(
    input  logic [WIDTH-1:0] i_valid,
    input  phys_t            i_reg   [WIDTH],
    output phys_t            o_data  [WIDTH],
    output num_t             o_count
);
    // Each valid slot lands in the next free lane, preserving slot order.
    always_comb begin
        o_count = '0;
        for (int k = 0; k < WIDTH; k++) o_data[k] = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (i_valid[k]) begin
                o_data[o_count[1:0]] = i_reg[k];
                o_count = o_count + 3'd1;
            end
        end
    end
endmodule

// File: rtl/spec_free_list.sv
// spec_free_list: circular speculative free list of physical registers, 4-wide pop and push
module spec_free_list
    import spec_free_list_pkg::*;
(
    input  logic clk,
    input  logic reset,
    spec_free_list_if.slave fl
);
    phys_t      r_mem [SIZE_FREE_LIST];
    ptr_t       r_head, r_tail;
    cnt_t       r_count;
    logic [3:0] w_req, w_rel_valid;
    phys_t      w_rel_reg [WIDTH];
    phys_t      w_wr_data [WIDTH];
    num_t       w_req_cnt, w_wr_cnt;
    logic       w_empty, w_pop;
    ptr_t       w_tail_next;
    cnt_t       w_count_next;

    assign w_req       = {fl.reqValid3_i, fl.reqValid2_i, fl.reqValid1_i, fl.reqValid0_i};
    assign w_rel_valid = {fl.releasedValid3_i, fl.releasedValid2_i, fl.releasedValid1_i, fl.releasedValid0_i};
    assign w_rel_reg   = '{fl.releasedPhyMap0_i, fl.releasedPhyMap1_i, fl.releasedPhyMap2_i, fl.releasedPhyMap3_i};

    free_list_write_align u_align (
        .i_valid (w_rel_valid),
        .i_reg   (w_rel_reg),
        .o_data  (w_wr_data),
        .o_count (w_wr_cnt)
    );

    // Allocation is all-or-nothing and judged on the pre-release count.
    assign w_req_cnt    = count4(w_req);
    assign w_empty      = cnt_t'(w_req_cnt) > r_count;
    assign w_pop        = (w_req_cnt != 3'd0) && !w_empty && !fl.recoverFlag_i;
    assign w_tail_next  = ptr_add(r_tail, w_wr_cnt);
    assign w_count_next = fl.recoverFlag_i ? cnt_t'(SIZE_FREE_LIST)
                        : r_count + cnt_t'(w_wr_cnt) - (w_pop ? cnt_t'(w_req_cnt) : cnt_t'(0));

    assign fl.freePhyReg0_o   = r_mem[r_head];
    assign fl.freePhyReg1_o   = r_mem[ptr_add(r_head, 3'd1)];
    assign fl.freePhyReg2_o   = r_mem[ptr_add(r_head, 3'd2)];
    assign fl.freePhyReg3_o   = r_mem[ptr_add(r_head, 3'd3)];
    assign fl.freeListEmpty_o = w_empty;
    assign fl.freeCount_o     = r_count;

    // Storage: reset to the unmapped registers, then released registers fill from the tail.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SIZE_FREE_LIST; i++) r_mem[i] <= phys_t'(SIZE_RMT + i);
        end else begin
            for (int k = 0; k < WIDTH; k++)
                if (num_t'(k) < w_wr_cnt) r_mem[ptr_add(r_tail, num_t'(k))] <= w_wr_data[k];
        end
    end

    // Pointers and count; recovery rewinds head so uncommitted allocations become free again.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= cnt_t'(SIZE_FREE_LIST);
        end else begin
            r_head  <= fl.recoverFlag_i ? w_tail_next : (w_pop ? ptr_add(r_head, w_req_cnt) : r_head);
            r_tail  <= w_tail_next;
            r_count <= w_count_next;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        w_count_next <= cnt_t'(SIZE_FREE_LIST));
    a_req_packed: assert property (@(posedge clk) disable iff (!reset)
        ((w_req + 4'd1) & w_req) == 4'd0);
endmodule

// File: doc/spec_free_list.md
Name: spec_free_list

Overview:
- Speculative physical-register free list. Sits between the architectural map table (producer of released physical registers at commit) and rename (consumer of free physical registers).
- Circular buffer. Accepts up to 4 in-order released registers per cycle and supplies up to 4 free registers per cycle to rename.
- Restores itself to full on recovery.

Parameters:
- SIZE_PHYSICAL_TABLE, 96, number of physical registers
- SIZE_RMT, 32, number of logical registers; regs 0..SIZE_RMT-1 are architecturally mapped at reset
- SIZE_PHYSICAL_LOG, 7, physical register index width
- SIZE_FREE_LIST, SIZE_PHYSICAL_TABLE-SIZE_RMT (64), buffer depth; need not be a power of two
- SIZE_FREE_LIST_LOG, 6, pointer width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- reqValid0_i..reqValid3_i  in  1 each  rename slot k needs a destination register; valids are packed (slot k valid implies slots 0..k-1 valid)
- freePhyReg0_o..freePhyReg3_o  out  SIZE_PHYSICAL_LOG each  entries at head, head+1, head+2, head+3 (mod depth), combinational from state
- freeListEmpty_o  out  1  stall: requested count > freeCount
- releasedValid0_i..releasedValid3_i  in  1 each  released-register valid; may be non-contiguous
- releasedPhyMap0_i..releasedPhyMap3_i  in  SIZE_PHYSICAL_LOG each  released register numbers
- recoverFlag_i  in  1  flush of all in-flight instructions
- freeCount_o  out  SIZE_FREE_LIST_LOG+1  current number of free entries

Behaviour:
- Reset (asynchronous, reset==0):
  - entry i = SIZE_RMT+i
  - head = 0, tail = 0, freeCount = SIZE_FREE_LIST (full)
  - outputs: freePhyReg0..3 = 32,33,34,35; freeListEmpty_o = 0; freeCount_o = 64
- Request count R = number of asserted reqValid (0..4). freeListEmpty_o = (R > freeCount), combinational.
- Pop, same edge: if R>0, !freeListEmpty_o and !recoverFlag_i, then head += R mod depth. Otherwise nothing is popped. All-or-nothing: partial allocation is never allowed.
- Push:
  - W = number of asserted releasedValid.
  - Valid released regs are compacted in slot order (0 first) and written to tail, tail+1, … (mod depth).
  - tail += W.
  - Pushes happen in every cycle, including recovery cycles.
- freeCount_next = freeCount + W − (pop ? R : 0), in the normal case.
- Simultaneous pop and push in one cycle are legal. A pop decision uses the pre-push freeCount; a same-cycle release cannot satisfy a same-cycle request.
- Recovery (recoverFlag_i=1): head <= tail_next, freeCount <= SIZE_FREE_LIST. Requests in that cycle are ignored.
  - Invariant: the slots between tail and old head hold exactly the uncommitted allocations, in allocation order.
  - Multi-cycle recoverFlag_i holds this state.
- Wrap-around: pointer reaching SIZE_FREE_LIST−1 continues at 0. Read addresses head+k and write addresses tail+k wrap independently.
- Overflow (freeCount_next > SIZE_FREE_LIST) cannot occur in a correct machine. It is flagged by a simulation assertion; RTL saturates nothing.
- Non-packed reqValid is illegal and covered by an assertion.

Decomposition:
- Shared package: SIZE_PHYSICAL_TABLE, SIZE_RMT, SIZE_PHYSICAL_LOG, SIZE_FREE_LIST(_LOG), commit/rename width constant (4).
- One sub-module: free_list_write_align. It is combinational: it compacts 4 valid/reg pairs into packed write data plus a count W (0..4). It is reused by any 4-wide in-order release path.
- Storage is a flop array inside spec_free_list: 4 read ports, 4 write ports.

Test Plan:
- Reset, then idle → freePhyReg0..3 = 32,33,34,35; freeCount_o=64; freeListEmpty_o=0. Assert reset mid-cycle with head=10 → immediate return to the same values without a clock edge.
- reqValid=1111 then 0111 → after edge 2, freeCount_o=57, freePhyReg0..3 = 39,40,41,42.
- Pop all 64 over 16 cycles while releasing valid=1010 with regs 5,9 in the last cycle → freeCount_o=2, freePhyReg0=5, freePhyReg1=9. Wrap covered: tail 0→2, head 64→0.
- freeCount=2, reqValid=0111 with release valid=0001 reg 77 → freeListEmpty_o=1, no pop, freeCount_o=3 next cycle. Next cycle same request → pop; outputs advance by 3.
- After reset, pop 10 (regs 32..41), release 2 regs (3,4) with no recovery, then recoverFlag_i with release valid=0001 reg 6 → freeCount_o=64. Next freePhyReg0..3 = 35,36,37,38 (oldest uncommitted). Tail entries hold 3,4,6.
- Recovery asserted together with reqValid=1111 → no pop; freeCount_o=64; freeListEmpty_o evaluated only after the recovery cycle.
